// File: rtl/conv_window_buffer.sv
// ---------------------------------------------------------------------------
// conv_window_buffer
//
// Sliding-window generator that feeds the 3x3 convolution multiplier. It takes
// a raster-order pixel stream and keeps KERNEL_SIZE-1 line buffers plus a
// KERNEL_SIZE x KERNEL_SIZE window register. Every window that lies fully
// inside the image is presented as one flat vector on shift_out.
//
// Optional feature: define CONV_WINDOW_FRAME_DONE_EN to add the frame_done
// output. It is a one-cycle pulse that coincides with the last window of a
// frame.
//
// Ports:
//   clk        in   clock; all logic is on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   pixel_in is valid
//   in_sof     in   start of frame; only meaningful when in_valid is high
//   pixel_in   in   [BITS-1:0] input pixel
//   in_ready   out  the block accepts a pixel this cycle
//   out_valid  out  shift_out holds a complete window
//   out_ready  in   the consumer takes the window
//   shift_out  out  [K*K*BITS-1:0] window. Element i = r*K + c is at
//                   bits [i*BITS +: BITS]. r=0 is the oldest (top) row and
//                   c=0 is the oldest (leftmost) column.
//   frame_done out  (CONV_WINDOW_FRAME_DONE_EN only) last-window pulse
// ---------------------------------------------------------------------------
module conv_window_buffer #(
    parameter int BITS        = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    input  logic                                  in_sof,
    input  logic [BITS-1:0]                       pixel_in,
    output logic                                  in_ready,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] shift_out
`ifdef CONV_WINDOW_FRAME_DONE_EN
    ,
    output logic                                  frame_done
`endif
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] LAST_COL      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW      = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] FIRST_WIN_COL = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] FIRST_WIN_ROW = RW'(KERNEL_SIZE - 1);

    logic [CW-1:0] col_reg, col_next, eff_col;
    logic [RW-1:0] row_reg, row_next, eff_row;
    logic          out_valid_reg;
    logic          accept;
    logic          qualify;
    logic          last_col;
    logic          last_row;

    // A single output register stage: a new pixel may enter whenever the
    // current window is empty or is being consumed in this same cycle.
    assign in_ready  = !out_valid_reg || out_ready;
    assign out_valid = out_valid_reg;
    assign accept    = in_valid && in_ready;

    // in_sof forces the incoming pixel to position (0,0) whatever the
    // counters say, so the line-buffer address and the window gating both use
    // this effective position.
    assign eff_col  = in_sof ? '0 : col_reg;
    assign eff_row  = in_sof ? '0 : row_reg;
    assign last_col = (eff_col == LAST_COL);
    assign last_row = (eff_row == LAST_ROW);
    assign qualify  = (eff_row >= FIRST_WIN_ROW) && (eff_col >= FIRST_WIN_COL);

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (accept) begin
            if (last_col) begin
                col_next = '0;
                row_next = last_row ? '0 : eff_row + 1'b1;
            end else begin
                col_next = eff_col + 1'b1;
                row_next = eff_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg       <= '0;
            row_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
            if (accept) begin
                out_valid_reg <= qualify;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Line buffers. g_line[j] holds the row that is j+1 rows above the
    // incoming pixel. They shift down as a column: buffer 0 takes the new
    // pixel and buffer j takes the old contents of buffer j-1 at the same
    // column. The read is asynchronous because the value has to enter the
    // window in the same cycle as the accept. The contents are not reset.
    // Row gating keeps stale data from ever reaching a valid window.
    // -----------------------------------------------------------------------
    genvar gi;
    genvar gc;

    for (gi = 0; gi < KERNEL_SIZE - 1; gi++) begin : g_line
        logic [BITS-1:0] mem [IMG_WIDTH];
        logic [BITS-1:0] wr_data;
        logic [BITS-1:0] rd_data;

        if (gi == 0) begin : g_first
            assign wr_data = pixel_in;
        end else begin : g_chain
            assign wr_data = g_line[gi-1].rd_data;
        end

        assign rd_data = mem[eff_col];

        always_ff @(posedge clk) begin
            if (accept) begin
                mem[eff_col] <= wr_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Window register. Each row shifts left by one column on accept. The new
    // right-hand column comes from pixel_in for the bottom row, and from the
    // line buffer that holds the matching older row for the other rows.
    // -----------------------------------------------------------------------
    for (gi = 0; gi < KERNEL_SIZE; gi++) begin : g_row
        logic [BITS-1:0] col_in;

        if (gi == KERNEL_SIZE - 1) begin : g_bottom
            assign col_in = pixel_in;
        end else begin : g_upper
            assign col_in = g_line[KERNEL_SIZE-2-gi].rd_data;
        end

        for (gc = 0; gc < KERNEL_SIZE; gc++) begin : g_col
            logic [BITS-1:0] cell_reg;
            logic [BITS-1:0] shift_src;

            if (gc == KERNEL_SIZE - 1) begin : g_right
                assign shift_src = col_in;
            end else begin : g_left
                assign shift_src = g_row[gi].g_col[gc+1].cell_reg;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cell_reg <= '0;
                end else if (accept) begin
                    cell_reg <= shift_src;
                end
            end

            // Only an accept changes the window, and an accept cannot occur
            // while a window waits under backpressure. The window register
            // can therefore drive the output directly.
            assign shift_out[(gi*KERNEL_SIZE+gc)*BITS +: BITS] = cell_reg;
        end
    end

`ifdef CONV_WINDOW_FRAME_DONE_EN
    logic frame_done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= accept && last_col && last_row;
        end
    end

    assign frame_done = frame_done_reg;
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_conv_window_buffer
//
// Bench for conv_window_buffer with a 4x4 image, KERNEL_SIZE=3 and BITS=32.
// A position-tracking image model pushes the expected window each time a
// qualifying pixel is accepted. Each window the DUT hands over is popped from
// that queue and compared. Scenarios: streaming, backpressure, two
// back-to-back frames, reset in the middle of a frame, and in_sof resync.
// ---------------------------------------------------------------------------
module tb_conv_window_buffer;

    localparam int BITS = 32;
    localparam int K    = 3;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int WW   = K * K * BITS;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_sof    = 1'b0;
    logic [BITS-1:0] pixel_in  = '0;
    logic            out_ready = 1'b1;
    logic            in_ready;
    logic            out_valid;
    logic [WW-1:0]   shift_out;
`ifdef CONV_WINDOW_FRAME_DONE_EN
    logic            frame_done;
    logic            fd_exp = 1'b0;
`endif

    always #5 clk = ~clk;

    conv_window_buffer #(
        .BITS        (BITS),
        .KERNEL_SIZE (K),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .pixel_in  (pixel_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .shift_out (shift_out)
`ifdef CONV_WINDOW_FRAME_DONE_EN
        ,
        .frame_done(frame_done)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [BITS-1:0] img [H][W];
    int              mrow = 0;
    int              mcol = 0;
    logic [WW-1:0]   exp_q  [$];
    logic [WW-1:0]   seen_q [$];
    int              win_cnt = 0;
    int              bp_left = 0;
    bit              bp_arm  = 1'b0;
    logic [WW-1:0]   held    = '0;

    task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // The window whose top-left pixel is (r0,c0) in a frame whose pixels
    // are base + raster index.
    function automatic logic [WW-1:0] build_win(input int base, input int r0, input int c0);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[(r*K+c)*BITS +: BITS] = BITS'(base + (r0 + r) * W + c0 + c);
        return w;
    endfunction

    task automatic model_reset();
        mrow = 0;
        mcol = 0;
        exp_q.delete();
`ifdef CONV_WINDOW_FRAME_DONE_EN
        fd_exp = 1'b0;
`endif
    endtask

    task automatic model_accept(input logic [BITS-1:0] pix, input logic sof);
        logic [WW-1:0] w;
        if (sof) begin
            mrow = 0;
            mcol = 0;
        end
        img[mrow][mcol] = pix;
        if (mrow >= K - 1 && mcol >= K - 1) begin
            w = '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    w[(r*K+c)*BITS +: BITS] = img[mrow-(K-1)+r][mcol-(K-1)+c];
            exp_q.push_back(w);
        end
`ifdef CONV_WINDOW_FRAME_DONE_EN
        fd_exp = (mrow == H - 1) && (mcol == W - 1);
`endif
        mcol++;
        if (mcol == W) begin
            mcol = 0;
            mrow++;
            if (mrow == H) mrow = 0;
        end
    endtask

    // One clock cycle. Outputs are sampled at the falling edge, inputs are
    // driven, and then handshakes are resolved for the next rising edge.
    task automatic cycle(input logic v, input logic sof, input logic [BITS-1:0] pix, output logic acc);
        logic [WW-1:0] e;
        @(negedge clk);
`ifdef CONV_WINDOW_FRAME_DONE_EN
        check_val("frame_done", frame_done, fd_exp);
        fd_exp = 1'b0;
`endif
        check_val("out_valid", out_valid, exp_q.size() != 0);
        if (bp_arm && out_valid) begin
            bp_left = 5;
            bp_arm  = 1'b0;
            held    = shift_out;
        end
        out_ready = (bp_left == 0);
        in_valid  = v;
        in_sof    = sof;
        pixel_in  = pix;
        #1;
        if (bp_left > 0) begin
            check_val("bp_in_ready", in_ready, 1'b0);
            check_val("bp_hold", shift_out, held);
            bp_left--;
        end
        if (out_valid && out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("window", shift_out, e);
            seen_q.push_back(shift_out);
            win_cnt++;
            $display("window %0d taken: elem0=%0d elem8=%0d", win_cnt,
                     shift_out[BITS-1:0], shift_out[WW-1 -: BITS]);
        end
        acc = v && in_ready;
        if (acc) model_accept(pix, sof);
    endtask

    task automatic send_pixel(input logic [BITS-1:0] pix, input logic sof);
        logic acc;
        for (int t = 0; t < 100; t++) begin
            cycle(1'b1, sof, pix, acc);
            if (acc) return;
        end
        check_val("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, acc);
    endtask

    task automatic send_frame(input int base, input logic sof_first);
        for (int i = 0; i < W * H; i++)
            send_pixel(BITS'(base + i), sof_first && (i == 0));
    endtask

    task automatic start_test();
        win_cnt = 0;
        seen_q.delete();
    endtask

    task automatic check_single_frame(input string tag);
        check_val({tag, "_count"}, WW'(win_cnt), WW'(4));
        if (seen_q.size() == 4) begin
            check_val({tag, "_w0"}, seen_q[0], build_win(0, 0, 0));
            check_val({tag, "_w1"}, seen_q[1], build_win(0, 0, 1));
            check_val({tag, "_w2"}, seen_q[2], build_win(0, 1, 0));
            check_val({tag, "_w3"}, seen_q[3], build_win(0, 1, 1));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_shift_out", shift_out, '0);
        rst_n = 1'b1;

        // Streaming, no sof; the counters must start at (0,0) after reset.
        start_test();
        send_frame(0, 1'b0);
        idle(3);
        check_single_frame("stream");

        // Backpressure on the first window.
        start_test();
        bp_arm = 1'b1;
        send_frame(0, 1'b0);
        idle(8);
        check_val("bp_armed_used", WW'(bp_arm), WW'(0));
        check_single_frame("bp");

        // Two back-to-back frames; sof on a pixel already at (0,0).
        start_test();
        send_frame(0, 1'b1);
        send_frame(100, 1'b0);
        idle(3);
        check_val("frames_count", WW'(win_cnt), WW'(8));
        if (seen_q.size() == 8) begin
            check_val("frames_w4", seen_q[4], build_win(100, 0, 0));
            check_val("frames_w7", seen_q[7], build_win(100, 1, 1));
        end

        // Reset in the middle of a frame. It is asserted between clock edges
        // after pixel 10, while the first window is pending.
        start_test();
        for (int i = 0; i <= 10; i++) send_pixel(BITS'(i), 1'b0);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("midrst_out_valid", out_valid, 1'b0);
        check_val("midrst_shift_out", shift_out, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        start_test();
        send_frame(0, 1'b0);
        idle(3);
        check_single_frame("midrst");

        // Partial frame, then resync with in_sof.
        start_test();
        for (int i = 0; i < 6; i++) send_pixel(BITS'(i), 1'b0);
        send_frame(0, 1'b1);
        idle(3);
        check_single_frame("sof");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
